pix_sq_err_stage: RTL

PIX_SQ_ERR_STAGE -- requirements
Module: pix_sq_err_stage

---
 rtl/pix_sq_err_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pix_sq_err_stage.sv
// Pixel squared-error stage: compares approximate-multiplier squares with exact op*op per channel.
// Latency: out_valid two cycles after acceptance, sustained 1 beat/cycle without backpressure.
// Backpressure: out_ready low stalls both stages in place; in_ready drops once stage 2 cannot drain.
//
// Ports:
//   clk, rst (sync, active-high), start (frame start pulse)
//   in_valid/in_ready, op_r/g/b [7:0], apx_r/g/b [15:0]   : upstream beat
//   out_valid/out_ready, out_r/g/b [7:0]                  : downstream beat (apx[15:8])
//   err_sum [ACC_W-1:0] (saturating), err_cnt, pix_cnt    : per-frame statistics
//   frame_done                                            : high in DONE
//   err_max [15:0]                                        : only with PIX_SQ_ERR_MAX_EN defined
// Optional feature macro: PIX_SQ_ERR_MAX_EN (adds err_max output and its tracking).
module pix_sq_err_stage #(
  parameter int NPIX  = 262144,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op_r,
  input  logic [7:0]       op_g,
  input  logic [7:0]       op_b,
  input  logic [15:0]      apx_r,
  input  logic [15:0]      apx_g,
  input  logic [15:0]      apx_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_r,
  output logic [7:0]       out_g,
  output logic [7:0]       out_b,
  output logic [ACC_W-1:0] err_sum,
  output logic [31:0]      err_cnt,
  output logic [31:0]      pix_cnt,
`ifdef PIX_SQ_ERR_MAX_EN
  output logic [15:0]      err_max,
`endif
  output logic             frame_done
);

  localparam logic [31:0] NPIX_W = 32'(NPIX);
  // One bit wider than both the accumulator and the 3-channel error sum, so overflow is visible.
  localparam int SUM_W = ((ACC_W > 18) ? ACC_W : 18) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_cnt_q, acc_cnt_d;
  logic             s1_vld_q, s1_vld_d;
  logic [2:0][15:0] s1_apx_q, s1_apx_d;
  logic [2:0][15:0] s1_sq_q, s1_sq_d;
  logic             s2_vld_q, s2_vld_d;
  logic [2:0][15:0] s2_err_q, s2_err_d;
  logic [2:0][7:0]  s2_byte_q, s2_byte_d;
  logic [ACC_W-1:0] err_sum_q, err_sum_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [31:0]      pix_cnt_q, pix_cnt_d;
`ifdef PIX_SQ_ERR_MAX_EN
  logic [15:0]      err_max_q, err_max_d;
`endif

  logic             adv, accept, consume;
  logic [2:0][7:0]  op_in;
  logic [2:0][15:0] apx_in, err_s1;
  logic [17:0]      err_tot;
  logic [SUM_W-1:0] sum_w;
  logic [31:0]      nz_cnt;

  always_comb begin
    // Channel index: 2 = r, 1 = g, 0 = b.
    op_in   = {op_r, op_g, op_b};
    apx_in  = {apx_r, apx_g, apx_b};
    adv     = !s2_vld_q || out_ready;
    in_ready = !rst && (state_q == RUN) && (acc_cnt_q < NPIX_W) && adv;
    accept  = in_valid && in_ready;
    consume = s2_vld_q && out_ready;

    for (int c = 0; c < 3; c++) begin
      err_s1[c] = (s1_apx_q[c] >= s1_sq_q[c]) ? (s1_apx_q[c] - s1_sq_q[c])
                                              : (s1_sq_q[c] - s1_apx_q[c]);
    end
    err_tot = 18'(s2_err_q[0]) + 18'(s2_err_q[1]) + 18'(s2_err_q[2]);
    sum_w   = SUM_W'(err_sum_q) + SUM_W'(err_tot);
    nz_cnt  = 32'(|s2_err_q[0]) + 32'(|s2_err_q[1]) + 32'(|s2_err_q[2]);

    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    s1_vld_d  = s1_vld_q;
    s1_apx_d  = s1_apx_q;
    s1_sq_d   = s1_sq_q;
    s2_vld_d  = s2_vld_q;
    s2_err_d  = s2_err_q;
    s2_byte_d = s2_byte_q;
    err_sum_d = err_sum_q;
    err_cnt_d = err_cnt_q;
    pix_cnt_d = pix_cnt_q;
`ifdef PIX_SQ_ERR_MAX_EN
    err_max_d = err_max_q;
`endif

    // Both stages shift together; when stage 2 is stuck, nothing moves.
    if (adv) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_apx_d = apx_in;
        for (int c = 0; c < 3; c++) s1_sq_d[c] = 16'(op_in[c]) * 16'(op_in[c]);
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_err_d = err_s1;
        for (int c = 0; c < 3; c++) s2_byte_d[c] = s1_apx_q[c][15:8];
      end
    end

    if (consume) begin
      err_sum_d = (|(sum_w >> ACC_W)) ? '1 : sum_w[ACC_W-1:0];
      err_cnt_d = err_cnt_q + nz_cnt;
      pix_cnt_d = pix_cnt_q + 32'd1;
`ifdef PIX_SQ_ERR_MAX_EN
      for (int c = 0; c < 3; c++) begin
        if (s2_err_q[c] > err_max_d) err_max_d = s2_err_q[c];
      end
`endif
    end

    case (state_q)
      IDLE, DONE: begin
        // Stages are empty here, so clearing cannot collide with a consume.
        if (start) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          err_sum_d = '0;
          err_cnt_d = '0;
          pix_cnt_d = '0;
`ifdef PIX_SQ_ERR_MAX_EN
          err_max_d = '0;
`endif
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 32'd1;
          if (acc_cnt_q == NPIX_W - 32'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_apx_q  <= '0;
      s1_sq_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_err_q  <= '0;
      s2_byte_q <= '0;
      err_sum_q <= '0;
      err_cnt_q <= '0;
      pix_cnt_q <= '0;
`ifdef PIX_SQ_ERR_MAX_EN
      err_max_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_apx_q  <= s1_apx_d;
      s1_sq_q   <= s1_sq_d;
      s2_vld_q  <= s2_vld_d;
      s2_err_q  <= s2_err_d;
      s2_byte_q <= s2_byte_d;
      err_sum_q <= err_sum_d;
      err_cnt_q <= err_cnt_d;
      pix_cnt_q <= pix_cnt_d;
`ifdef PIX_SQ_ERR_MAX_EN
      err_max_q <= err_max_d;
`endif
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_r      = s2_byte_q[2];
  assign out_g      = s2_byte_q[1];
  assign out_b      = s2_byte_q[0];
  assign err_sum    = err_sum_q;
  assign err_cnt    = err_cnt_q;
  assign pix_cnt    = pix_cnt_q;
  assign frame_done = (state_q == DONE);
`ifdef PIX_SQ_ERR_MAX_EN
  assign err_max    = err_max_q;
`endif

endmodule
